// File: rtl/can_frame_receiver.sv
// CAN 2.0A receiver: destuffs the bitstream, parses standard data/remote frames,
// checks CRC-15 and form bits. Define CAN_RX_ACK_EN to drive a dominant ACK on good CRC.
//
// state     | meaning
// WAIT_IDLE | after reset, counting IDLE_BITS recessive bits
// IDLE      | bus idle, waiting for a dominant SOF
// ARB       | 11 ID bits then RTR
// CTRL      | IDE, r0, 4 DLC bits
// DATA      | 8*bytecount data bits
// CRC       | 15 received CRC bits
// CRC_DEL   | CRC delimiter, CRC compare
// ACK_SLOT  | ACK slot, any value
// ACK_DEL   | ACK delimiter
// EOF       | EOF_BITS recessive bits
// ERROR     | after an error, counting IDLE_BITS recessive bits
module can_frame_receiver #(
  parameter int IDLE_BITS = 11,
  parameter int EOF_BITS  = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  output logic [75:0] rx_payload,
  output logic [3:0]  rx_dlc,
  output logic        rx_valid,
  output logic        crc_err,
  output logic        stuff_err,
  output logic        form_err,
  output logic        ack_tx,
  output logic        busy
);

  localparam int IDLE_W = $clog2(IDLE_BITS + 1);

  typedef enum logic [3:0] {
    WAIT_IDLE, IDLE, ARB, CTRL, DATA, CRC, CRC_DEL, ACK_SLOT, ACK_DEL, EOF, ERROR
  } state_t;

  state_t            state_q;
  logic [IDLE_W-1:0] idle_cnt_q;
  logic [6:0]        cnt_q;
  logic [2:0]        run_q;
  logic              last_q;
  logic [14:0]       crc_q;
  logic [14:0]       crc_rx_q;
  logic [11:0]       arb_q;
  logic [3:0]        dlc_q;
  logic [63:0]       data_q;
  logic [6:0]        shamt_q;
  logic [75:0]       payload_q;
  logic [3:0]        rx_dlc_q;
  logic              valid_q;
  logic              crc_err_q;
  logic              stuff_err_q;
  logic              form_err_q;
  logic              busy_q;

  logic              in_stuff_region;
  logic              stuff_bit;
  logic              crc_ok;
  logic [14:0]       crc_d;
  logic [3:0]        dlc_d;
  logic [3:0]        nbytes_d;

  always_comb begin
    in_stuff_region = (state_q == ARB) || (state_q == CTRL) ||
                      (state_q == DATA) || (state_q == CRC);
    stuff_bit = in_stuff_region && (run_q == 3'd5);
    crc_d     = {crc_q[13:0], 1'b0} ^ ((crc_q[14] ^ rx) ? 15'h4599 : 15'h0000);
    crc_ok    = (crc_q == crc_rx_q);
    dlc_d     = {dlc_q[2:0], rx};
    nbytes_d  = 4'd0;
    if (!arb_q[0]) nbytes_d = dlc_d[3] ? 4'd8 : dlc_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= WAIT_IDLE;
      idle_cnt_q  <= '0;
      cnt_q       <= '0;
      run_q       <= '0;
      last_q      <= 1'b0;
      crc_q       <= '0;
      crc_rx_q    <= '0;
      arb_q       <= '0;
      dlc_q       <= '0;
      data_q      <= '0;
      shamt_q     <= '0;
      payload_q   <= '0;
      rx_dlc_q    <= '0;
      valid_q     <= 1'b0;
      crc_err_q   <= 1'b0;
      stuff_err_q <= 1'b0;
      form_err_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      valid_q     <= 1'b0;
      crc_err_q   <= 1'b0;
      stuff_err_q <= 1'b0;
      form_err_q  <= 1'b0;
      // Stuff bits are consumed here and never reach the field logic below.
      if (stuff_bit) begin
        run_q  <= 3'd1;
        last_q <= rx;
        if (rx == last_q) begin
          stuff_err_q <= 1'b1;
          state_q     <= ERROR;
          busy_q      <= 1'b0;
        end
      end else begin
        if (in_stuff_region) begin
          run_q  <= (rx == last_q) ? run_q + 3'd1 : 3'd1;
          last_q <= rx;
        end
        case (state_q)
          WAIT_IDLE, ERROR: begin
            if (!rx) begin
              idle_cnt_q <= '0;
            end else if (idle_cnt_q == IDLE_W'(IDLE_BITS - 1)) begin
              idle_cnt_q <= '0;
              state_q    <= IDLE;
            end else begin
              idle_cnt_q <= idle_cnt_q + IDLE_W'(1);
            end
          end
          IDLE: begin
            if (!rx) begin
              state_q <= ARB;
              cnt_q   <= 7'd11;
              run_q   <= 3'd1;
              last_q  <= 1'b0;
              crc_q   <= '0;
              data_q  <= '0;
              busy_q  <= 1'b1;
            end
          end
          ARB: begin
            crc_q <= crc_d;
            arb_q <= {arb_q[10:0], rx};
            if (cnt_q == 7'd0) begin
              state_q <= CTRL;
              cnt_q   <= 7'd5;
            end else begin
              cnt_q <= cnt_q - 7'd1;
            end
          end
          CTRL: begin
            crc_q <= crc_d;
            cnt_q <= cnt_q - 7'd1;
            if (cnt_q <= 7'd3) dlc_q <= dlc_d;
            if (cnt_q == 7'd5 && rx) begin
              form_err_q <= 1'b1;
              state_q    <= ERROR;
              busy_q     <= 1'b0;
            end
            if (cnt_q == 7'd0) begin
              shamt_q <= 7'd64 - {nbytes_d, 3'b000};
              if (nbytes_d == 4'd0) begin
                state_q <= CRC;
                cnt_q   <= 7'd14;
              end else begin
                state_q <= DATA;
                cnt_q   <= {nbytes_d, 3'b000} - 7'd1;
              end
            end
          end
          DATA: begin
            crc_q  <= crc_d;
            data_q <= {data_q[62:0], rx};
            if (cnt_q == 7'd0) begin
              state_q <= CRC;
              cnt_q   <= 7'd14;
            end else begin
              cnt_q <= cnt_q - 7'd1;
            end
          end
          CRC: begin
            crc_rx_q <= {crc_rx_q[13:0], rx};
            if (cnt_q == 7'd0) state_q <= CRC_DEL;
            else               cnt_q   <= cnt_q - 7'd1;
          end
          CRC_DEL: begin
            if (!crc_ok) crc_err_q  <= 1'b1;
            if (!rx)     form_err_q <= 1'b1;
            if (!crc_ok || !rx) begin
              state_q <= ERROR;
              busy_q  <= 1'b0;
            end else begin
              state_q <= ACK_SLOT;
            end
          end
          ACK_SLOT: state_q <= ACK_DEL;
          ACK_DEL: begin
            if (!rx) begin
              form_err_q <= 1'b1;
              state_q    <= ERROR;
              busy_q     <= 1'b0;
            end else begin
              state_q <= EOF;
              cnt_q   <= 7'(EOF_BITS - 1);
            end
          end
          EOF: begin
            if (!rx) begin
              form_err_q <= 1'b1;
              state_q    <= ERROR;
              busy_q     <= 1'b0;
            end else if (cnt_q == 7'd0) begin
              // Bytes arrive right-aligned; shift so byte0 lands in [63:56].
              payload_q <= {arb_q[0], arb_q[11:1], data_q << shamt_q};
              rx_dlc_q  <= dlc_q;
              valid_q   <= 1'b1;
              state_q   <= IDLE;
              busy_q    <= 1'b0;
            end else begin
              cnt_q <= cnt_q - 7'd1;
            end
          end
          default: begin
            state_q <= WAIT_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef CAN_RX_ACK_EN
  logic ack_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ack_q <= 1'b1;
    else      ack_q <= !((state_q == CRC_DEL) && rx && crc_ok);
  end

  assign ack_tx = ack_q;
`else
  assign ack_tx = 1'b1;
`endif

  assign rx_payload = payload_q;
  assign rx_dlc     = rx_dlc_q;
  assign rx_valid   = valid_q;
  assign crc_err    = crc_err_q;
  assign stuff_err  = stuff_err_q;
  assign form_err   = form_err_q;
  assign busy       = busy_q;

endmodule

// File: doc/can_frame_receiver.md
Name: can_frame_receiver

Overview:
- Consumes the serial CAN bitstream produced by the frame generator and recovers the message. It sits directly downstream of the generator's txgen output, or of the bus model in the testbench.
- Samples one bit per clk and removes stuff bits. Parses standard (11-bit ID) data and remote frames, checks CRC-15 and form bits, then presents the result as a 76-bit payload in the same packing the generator accepts.
- Lets the bench close the loop: generator payload -> bus -> receiver payload, followed by a compare.

Parameters:
- IDLE_BITS, 11, number of consecutive recessive bits required before IDLE accepts a new SOF (after reset and after any error).
- EOF_BITS, 7, number of recessive end-of-frame bits checked.

Ports:
- clk  input  1  bit clock; one CAN bit per rising edge.
- rst  input  1  asynchronous, active-low reset.
- rx  input  1  serial bus bit; 1 = recessive.
- rx_payload  output  76  [75]=RTR, [74:64]=ID, [63:0]=data with byte0 in [63:56]; bytes not received are 0.
- rx_dlc  output  4  DLC field exactly as received.
- rx_valid  output  1  one-clk pulse; frame is good and rx_payload/rx_dlc are updated.
- crc_err  output  1  one-clk pulse; CRC mismatch.
- stuff_err  output  1  one-clk pulse; six equal consecutive bits seen inside the stuffed region.
- form_err  output  1  one-clk pulse; a fixed-form bit is wrong, or IDE=1 (extended frames unsupported).
- ack_tx  output  1  ACK drive; 0 = dominant.
- busy  output  1  high from SOF until return to IDLE.

Behaviour:
- Reset (async): state=WAIT_IDLE, rx_payload=0, rx_dlc=0, all pulse outputs=0, ack_tx=1, busy=0, idle counter=0, CRC=0.
- States: WAIT_IDLE, IDLE, ARB, CTRL, DATA, CRC, CRC_DEL, ACK_SLOT, ACK_DEL, EOF, ERROR.

State transitions:
- WAIT_IDLE: count consecutive rx=1. Any rx=0 clears the count. Reaching IDLE_BITS -> IDLE.
- IDLE: rx=0 is SOF -> ARB. The stuff counter is set to 1 with last bit 0, CRC starts at 0, busy=1.
- ARB: 11 ID bits, MSB first, then RTR -> CTRL.
- CTRL: IDE, r0, then 4 DLC bits.
  - IDE=1 -> form_err.
  - r0 is not checked.
  - Byte count = 0 if RTR=1; otherwise min(DLC,8). DLC values 9..15 therefore mean 8 bytes.
  - Byte count 0 -> CRC; otherwise -> DATA.
- DATA: 8*bytecount bits, MSB first, byte0 first -> CRC.
- CRC: 15 bits received and compared with the running CRC -> CRC_DEL.
- CRC_DEL: must be 1, else form_err. A CRC mismatch pulses crc_err in this cycle -> ERROR.
- ACK_SLOT: any value accepted -> ACK_DEL.
- ACK_DEL: must be 1, else form_err -> EOF.
- EOF: EOF_BITS bits, all must be 1, else form_err.
  - On the last good bit, the next clk has rx_valid=1 and rx_payload/rx_dlc are updated.
  - State returns to IDLE; bus idle is implied by EOF plus intermission.

Bit destuffing (SOF through the last CRC bit only):
- After 5 equal consecutive bits, the next bit is a stuff bit. It is discarded and not fed to the CRC or the field counters.
- If that stuff bit equals the previous bit -> stuff_err -> ERROR.
- A stuff bit resets the run count to 1 with its own value.

CRC:
- CRC-15, polynomial 0x4599, init 0.
- Computed over destuffed SOF, ARB, CTRL and DATA bits.
- crc_next = {crc[13:0],1'b0} ^ (crc[14]^bit ? 15'h4599 : 0).

Errors:
- Every error pulses for exactly one clk and goes to ERROR. ERROR behaves as WAIT_IDLE: wait for IDLE_BITS recessive, then IDLE.
- rx_payload is never updated by a bad frame.
- If several errors occur on the same bit, all applicable flags pulse together.

Other rules:
- Reset mid-frame aborts the frame with no pulses, and the receiver restarts in WAIT_IDLE.
- busy drops on the cycle the state returns to IDLE or enters ERROR/WAIT_IDLE.

Optional Feature:
- Macro: CAN_RX_ACK_EN.
- Defined: ack_tx=0 during exactly the ACK_SLOT bit when the CRC compared equal and no error is pending; otherwise ack_tx=1.
- Undefined: ack_tx is tied to 1 and the receiver is a pure listener. Reception behaviour is otherwise identical.

Test Plan:
- Good data frame: after IDLE_BITS recessive, generator sends ID=0x555, DLC=8, data=0x0123456789ABCDEF -> one rx_valid pulse, rx_payload=76'h0_555_0123456789ABCDEF, rx_dlc=8, no error pulses.
- Short data frame: DLC=2, data bytes 0xA5,0x3C -> rx_payload[63:0]=64'hA53C000000000000, rx_dlc=2. Then send DLC=12 with 8 bytes -> rx_dlc=12, all 8 bytes captured.
- CRC corruption: flip one CRC bit of the good frame (re-stuffed correctly) -> crc_err pulses at CRC_DEL, no rx_valid, rx_payload keeps its previous value. The next good frame is received after 11 recessive bits.
- Stuff violation: ID=0x000 with the stuff bit forced to 0 -> stuff_err pulses on the 6th dominant bit, busy drops, rx_valid stays 0.
- Remote and IDE: RTR=1, DLC=4 -> rx_valid, rx_payload[75]=1, data=0. A frame with IDE=1 -> form_err.
- Reset and ACK: assert rst during DATA -> outputs return to reset values, and no pulse occurs for that frame. With CAN_RX_ACK_EN defined, a good frame drives ack_tx=0 for exactly the one ACK slot clk.
